// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM bulk loader/dumper: FSM state encoding and default widths.
package ram_loader_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LD_WAIT = 3'd1,
    ST_LD_WR   = 3'd2,
    ST_DP_RD   = 3'd3,
    ST_DP_CAP  = 3'd4,
    ST_DP_OUT  = 3'd5,
    ST_FIN     = 3'd6
  } state_e;

endpackage

// File: rtl/ram_loader.sv
// Bus-side initiator that streams a byte image into the RAM and dumps it back out,
// holding RAM ownership away from the CPU for the whole operation.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_load_i,
  input  logic              start_dump_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_ri_o,
  input  logic [DATA_W-1:0] ram_dout_i,
  output logic              hold_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int                LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST     = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              in_ready_q, out_valid_q, ram_ri_q, busy_q, done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    din_d      = din_q;
    out_data_d = out_data_q;
    lat_d      = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_load_i) begin
          state_d = ST_LD_WAIT;
          addr_d  = '0;
        end else if (start_dump_i) begin
          state_d = ST_DP_RD;
          addr_d  = '0;
          lat_d   = LAT_INIT;
        end
      end
      ST_LD_WAIT: begin
        if (in_valid_i) begin
          din_d   = in_data_i;
          state_d = ST_LD_WR;
        end
      end
      // Terminal address is tested before incrementing so the counter never wraps.
      ST_LD_WR: begin
        if (addr_q == LAST) begin
          state_d = ST_FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LD_WAIT;
        end
      end
      ST_DP_RD: begin
        if (lat_q == '0) state_d = ST_DP_CAP;
        else             lat_d   = lat_q - 1'b1;
      end
      ST_DP_CAP: begin
        out_data_d = ram_dout_i;
        state_d    = ST_DP_OUT;
      end
      ST_DP_OUT: begin
        if (out_ready_i) begin
          if (addr_q == LAST) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            lat_d   = LAT_INIT;
            state_d = ST_DP_RD;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A write already presented in LD_WR still lands on this edge; abort only stops what follows.
    if (abort_i && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      out_data_q  <= '0;
      lat_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ram_ri_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      out_data_q  <= out_data_d;
      lat_q       <= lat_d;
      in_ready_q  <= (state_d == ST_LD_WAIT);
      out_valid_q <= (state_d == ST_DP_OUT);
      ram_ri_q    <= (state_d == ST_LD_WR);
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_FIN);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign ram_addr_o  = addr_q;
  assign ram_din_o   = din_q;
  assign ram_ri_o    = ram_ri_q;
  assign busy_o      = busy_q;
  assign hold_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: behavioural 16x8 RAM on the RAM side, byte-stream
// driver on the load side and a stall-pattern consumer on the dump side.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_load = 1'b0, start_dump = 1'b0, abort = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready = 1'b0;
  logic [3:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_ri, hold, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_mem [16];
  logic [7:0] mem [16];

  ram_loader #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .start_load_i(start_load), .start_dump_i(start_dump), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_ri_o(ram_ri),
    .ram_dout_i(ram_dout), .hold_o(hold), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // RAM model: one-cycle registered read, reads 0 while write enable is high.
  always @(posedge clk) begin
    if (ram_ri) mem[ram_addr] <= ram_din;
    ram_dout <= ram_ri ? 8'h00 : mem[ram_addr];
  end

  // Bus monitors: counts only, judged later by the bench.
  int         done_cnt = 0;
  int         ri_cnt = 0;
  int         ri_consec = 0;
  int         ri_overlap = 0;
  logic       prev_ri = 1'b0;
  logic [3:0] ri_log [256];
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (ram_ri) begin
      ri_log[ri_cnt[7:0]] <= ram_addr;
      ri_cnt <= ri_cnt + 1;
      if (prev_ri) ri_consec <= ri_consec + 1;
      if (in_ready || out_valid) ri_overlap <= ri_overlap + 1;
    end
    prev_ri <= ram_ri;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pulse(input logic ld, input logic dp);
    @(negedge clk);
    start_load = ld;
    start_dump = dp;
    @(negedge clk);
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("feed_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_ld_order(input string tag, input int from, input int count);
    int bad = 0;
    for (int k = 0; k < count; k++)
      if (ri_log[(from + k) % 256] != 4'(k)) bad++;
    check(tag, bad, 0);
  endtask

  // mode 0: always ready; mode 1: ready one cycle in three.
  task automatic dump(input string name, input int mode);
    logic [7:0] got [16];
    int         n = 0;
    int         hold_err = 0;
    int         d0 = done_cnt;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    pulse(1'b0, 1'b1);
    for (int cyc = 0; cyc < 400 && n < 16; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      if (prev_stall && (!out_valid || out_data != prev_data)) hold_err++;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
    end
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check({name, "_count"}, n, 16);
    for (int i = 0; i < 16; i++)
      if (i < n) check($sformatf("%s_byte%0d", name, i), got[i], exp_mem[i]);
    check({name, "_hold"}, hold_err, 0);
    check({name, "_done"}, done_cnt - d0, 1);
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
    $display("dump %s: %0d bytes received", name, n);
  endtask

  initial begin
    int d0;
    int r0;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_hold", {31'd0, hold}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_ri", {31'd0, ram_ri}, 0);
    check("rst_addr", {28'd0, ram_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back load 0x10..0x1F, then dump with ready always high
    d0 = done_cnt;
    r0 = ri_cnt;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      feed(8'h10 + 8'(i), 0);
      exp_mem[i] = 8'h10 + 8'(i);
    end
    repeat (4) @(negedge clk);
    check("t1_ri_count", ri_cnt - r0, 16);
    check_ld_order("t1_ld_order", r0, 16);
    check("t1_done", done_cnt - d0, 1);
    check("t1_idle", {31'd0, busy}, 0);
    $display("load t1: %0d writes", ri_cnt - r0);
    dump("t1_dump", 0);

    // 2: dump with OUT_READY one cycle in three
    dump("t2_dump", 1);

    // 3: load with 0..5 cycle gaps
    d0 = done_cnt;
    r0 = ri_cnt;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      feed(8'hA0 + 8'(i), i % 6);
      exp_mem[i] = 8'hA0 + 8'(i);
    end
    repeat (4) @(negedge clk);
    check("t3_ri_count", ri_cnt - r0, 16);
    check_ld_order("t3_ld_order", r0, 16);
    check("t3_ri_consec", ri_consec, 0);
    check("t3_ri_overlap", ri_overlap, 0);
    check("t3_done", done_cnt - d0, 1);
    $display("load t3: %0d writes with gaps", ri_cnt - r0);

    // 4: both starts at once -> load; start_dump mid-load ignored
    d0 = done_cnt;
    pulse(1'b1, 1'b1);
    check("t4_in_ready", {31'd0, in_ready}, 1);
    check("t4_no_dump", {31'd0, out_valid}, 0);
    for (int i = 0; i < 3; i++) feed(8'h30 + 8'(i), 0);
    pulse(1'b0, 1'b1);
    check("t4_mid_in_ready", {31'd0, in_ready}, 1);
    check("t4_mid_addr", {28'd0, ram_addr}, 3);
    check("t4_mid_no_dump", {31'd0, out_valid}, 0);
    for (int i = 3; i < 16; i++) feed(8'h30 + 8'(i), 1);
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h30 + 8'(i);
    repeat (4) @(negedge clk);
    check("t4_done", done_cnt - d0, 1);
    $display("load t4: done pulses %0d", done_cnt - d0);

    // 5: abort while the 5th byte is being written
    d0 = done_cnt;
    r0 = ri_cnt;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      feed(8'h50 + 8'(i), 0);
      exp_mem[i] = 8'h50 + 8'(i);
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", {31'd0, busy}, 0);
    check("t5_in_ready", {31'd0, in_ready}, 0);
    repeat (3) @(negedge clk);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_ri_count", ri_cnt - r0, 5);
    $display("abort t5: %0d writes committed", ri_cnt - r0);
    dump("t5_dump", 0);

    // 6: reset during DP_OUT at addr 9
    pulse(1'b0, 1'b1);
    out_ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (out_valid && ram_addr == 4'd9) begin
        out_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("t6_reached", {27'd0, out_valid, ram_addr}, {27'd0, 1'b1, 4'd9});
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_hold", {31'd0, hold}, 0);
    check("t6_out_valid", {31'd0, out_valid}, 0);
    check("t6_out_data", {24'd0, out_data}, 0);
    check("t6_addr", {28'd0, ram_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset t6: outputs cleared mid-dump");
    dump("t6_dump", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
